pad_event_arbiter: RTL

//  Consumes the two 128-bit gamepad report registers (left pad ldata, right pad rdata) from the SPI

---
 rtl/pad_event_arbiter_if.sv | 21 ++
 rtl/pad_event_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/pad_event_arbiter_if.sv
// Event stream from pad_event_arbiter to game logic.
// The interface carries a valid/ready handshake and the snapshot payload.
interface pad_event_arbiter_if;
  logic        evt_valid;
  logic        evt_ready;
  logic        evt_pad;
  logic [15:0] evt_buttons;
  logic [7:0]  evt_x;
  logic [7:0]  evt_y;
  logic [15:0] evt_pressed;

  modport master (
    output evt_valid, evt_pad, evt_buttons, evt_x, evt_y, evt_pressed,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_pad, evt_buttons, evt_x, evt_y, evt_pressed,
    output evt_ready
  );
endinterface

// File: rtl/pad_event_arbiter.sv
// Detects meaningful per-pad changes in the two gamepad reports and coalesces them.
// It round-robins the resulting snapshots onto a single valid/ready event stream.
module pad_event_arbiter #(
  parameter logic [15:0] BTN_MASK = 16'hFFFF,
  parameter bit          AXIS_EN  = 1'b1,
  parameter logic [7:0]  DEADBAND = 8'd0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [127:0]        ldata,
  input  logic [127:0]        rdata,
  pad_event_arbiter_if.master evt,
  output logic [7:0]          drop_cnt
);

  typedef struct packed {
    logic [15:0] btn;
    logic [7:0]  x;
    logic [7:0]  y;
  } pad_rep_t;

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_e;

  pad_rep_t    in_s       [2];
  pad_rep_t    sh_q       [2];
  pad_rep_t    snap_q     [2];
  logic [15:0] prev_btn_q [2];
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  trig;
  logic        last_grant_q;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  state_e      state_q, state_d;
  logic        load_evt;
  logic        grant;
  logic        evt_pad_q;
  pad_rep_t    evt_rep_q;
  logic [15:0] evt_pressed_q;
  logic        unused_bytes;

  // Only the button word and the two axis bytes matter; pad id and trailing bytes are dropped.
  assign in_s[0] = {ldata[23:8], ldata[31:24], ldata[39:32]};
  assign in_s[1] = {rdata[23:8], rdata[31:24], rdata[39:32]};
  assign unused_bytes = ^{ldata[7:0], ldata[127:40], rdata[7:0], rdata[127:40]};

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[8] ? (b - a) : d[7:0];
  endfunction

  always_comb begin
    trig = '0;
    for (int p = 0; p < 2; p++) begin
      trig[p] = (|((in_s[p].btn ^ sh_q[p].btn) & BTN_MASK))
             || (AXIS_EN && ((absdiff(in_s[p].x, sh_q[p].x) > DEADBAND)
                          || (absdiff(in_s[p].y, sh_q[p].y) > DEADBAND)));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pend_q) state_d = PRESENT;
      PRESENT: if (evt.evt_ready) state_d = IDLE;
    endcase
  end

  always_comb begin
    load_evt      = (state_q == IDLE) && (|pend_q);
    grant         = (pend_q == 2'b11) ? ~last_grant_q : pend_q[1];
    evt.evt_valid = (state_q == PRESENT);
  end

  // A snapshot granted this cycle has been delivered, so re-triggering that pad is not a drop.
  always_comb begin
    logic [8:0] drop_sum;
    pend_d   = pend_q;
    drop_sum = {1'b0, drop_cnt_q};
    if (load_evt) pend_d[grant] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (trig[p]) begin
        if (pend_d[p]) drop_sum = drop_sum + 9'd1;
        pend_d[p] = 1'b1;
      end
    end
    drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_q        <= '0;
      drop_cnt_q    <= '0;
      last_grant_q  <= 1'b1;
      evt_pad_q     <= 1'b0;
      evt_rep_q     <= '0;
      evt_pressed_q <= '0;
      for (int p = 0; p < 2; p++) begin
        sh_q[p]       <= '0;
        prev_btn_q[p] <= '0;
      end
    end else begin
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
      for (int p = 0; p < 2; p++) begin
        if (trig[p]) sh_q[p] <= in_s[p];
      end
      if (load_evt) begin
        evt_pad_q         <= grant;
        evt_rep_q         <= snap_q[grant];
        evt_pressed_q     <= snap_q[grant].btn & ~prev_btn_q[grant];
        prev_btn_q[grant] <= snap_q[grant].btn;
        last_grant_q      <= grant;
      end
    end
  end

  // NOTE: snapshot storage is not reset; a snapshot is only read while its pending bit is set.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (trig[p]) snap_q[p] <= in_s[p];
    end
  end

  assign evt.evt_pad     = evt_pad_q;
  assign evt.evt_buttons = evt_rep_q.btn;
  assign evt.evt_x       = evt_rep_q.x;
  assign evt.evt_y       = evt_rep_q.y;
  assign evt.evt_pressed = evt_pressed_q;
  assign drop_cnt        = drop_cnt_q;

endmodule
